// File: rtl/sar_responder.sv
// sar_responder
// Digital stand-in for the analog front-end on the SAR controller's
// ms_sar_* port. It tracks an integer input code while ms_sar_sample is high
// and holds it when sample falls. Each ms_sar_clock rise is a comparison
// request. The held code is compared against the trial code on ms_sar_sw,
// and the answer is returned on ms_sar_dh/ms_sar_dl with an ms_sar_rdy
// handshake.
//
// Ports:
//   clk          sampling clock (controller f100m_clk domain)
//   rst          asynchronous active-high reset
//   vin_code     unsigned input code tracked while sampling
//   ms_sar_sample  high = track, falling edge = hold
//   ms_sar_clock   rising edge = comparison request, falling edge = release
//   ms_sar_sw      trial DAC code
//   ms_sar_swb     complement of the trial code (checked at request)
//   ms_sar_dh      held code above trial
//   ms_sar_dl      held code below trial
//   ms_sar_rdy     comparison result valid
//   held_code      current held or tracked value
//   prot_err       sticky protocol-violation flag
module sar_responder #(
    parameter int NSTEP   = 8,
    parameter int RDY_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NSTEP-1:0] vin_code,
    input  logic             ms_sar_sample,
    input  logic             ms_sar_clock,
    input  logic [NSTEP-1:0] ms_sar_sw,
    input  logic [NSTEP-1:0] ms_sar_swb,
    output logic             ms_sar_dh,
    output logic             ms_sar_dl,
    output logic             ms_sar_rdy,
    output logic [NSTEP-1:0] held_code,
    output logic             prot_err
);

    typedef enum logic [2:0] {
        IDLE,
        TRACK,
        HOLD,
        CONV,
        READY
    } state_t;

    // Loaded on CONV entry; the result fires on the edge that finds it at 0,
    // giving rdy exactly RDY_LAT edges after the request edge.
    localparam logic [3:0] LAT_LOAD = 4'(RDY_LAT - 1);

    state_t           state_q;
    logic             sample_q;
    logic             clock_q;
    logic [3:0]       cnt_q;
    logic [NSTEP-1:0] trial_q;
    logic [NSTEP-1:0] held_q;
    logic             dh_q;
    logic             dl_q;
    logic             rdy_q;
    logic             err_q;

    logic sampleRise;
    logic sampleFall;
    logic clockRise;
    logic clockFall;
    logic swbBad;

    assign sampleRise = ms_sar_sample & ~sample_q;
    assign sampleFall = ~ms_sar_sample & sample_q;
    assign clockRise  = ms_sar_clock & ~clock_q;
    assign clockFall  = ~ms_sar_clock & clock_q;
    assign swbBad     = (ms_sar_swb != ~ms_sar_sw);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sample_q <= 1'b0;
            clock_q  <= 1'b0;
            cnt_q    <= 4'd0;
            trial_q  <= '0;
            held_q   <= '0;
            dh_q     <= 1'b0;
            dl_q     <= 1'b0;
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sample_q <= ms_sar_sample;
            clock_q  <= ms_sar_clock;

            // Tracking is driven straight from the sampled input, so the last
            // captured value is vin_code at the final edge with sample high.
            if (ms_sar_sample) begin
                held_q <= vin_code;
            end

            // A request while not holding, or together with a sample rise,
            // is a protocol violation; the sample rise always wins below.
            if (clockRise && (sampleRise || state_q == IDLE || state_q == TRACK)) begin
                err_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (ms_sar_sample) begin
                        state_q <= TRACK;
                    end
                end

                TRACK: begin
                    if (sampleFall) begin
                        state_q <= HOLD;
                    end
                end

                HOLD: begin
                    // rdy is dropped here rather than on the READY exit edge,
                    // so it falls one edge after the release is sampled.
                    rdy_q <= 1'b0;
                    if (sampleRise) begin
                        state_q <= TRACK;
                        dh_q    <= 1'b0;
                        dl_q    <= 1'b0;
                    end else if (clockRise) begin
                        state_q <= CONV;
                        cnt_q   <= LAT_LOAD;
                        trial_q <= ms_sar_sw;
                        dh_q    <= 1'b0;
                        dl_q    <= 1'b0;
                        if (swbBad) begin
                            err_q <= 1'b1;
                        end
                    end
                end

                CONV: begin
                    if (sampleRise) begin
                        state_q <= TRACK;
                        rdy_q   <= 1'b0;
                        dh_q    <= 1'b0;
                        dl_q    <= 1'b0;
                    end else if (clockFall) begin
                        state_q <= HOLD;
                    end else if (cnt_q == 4'd0) begin
                        dh_q    <= (held_q > trial_q);
                        dl_q    <= (held_q < trial_q);
                        rdy_q   <= 1'b1;
                        state_q <= READY;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                READY: begin
                    if (sampleRise) begin
                        state_q <= TRACK;
                        rdy_q   <= 1'b0;
                        dh_q    <= 1'b0;
                        dl_q    <= 1'b0;
                    end else if (clockFall) begin
                        state_q <= HOLD;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ms_sar_dh  = dh_q;
    assign ms_sar_dl  = dl_q;
    assign ms_sar_rdy = rdy_q;
    assign held_code  = held_q;
    assign prot_err   = err_q;

endmodule

// File: tb/tb_sar_responder.sv
// tb_sar_responder
// Self-checking bench for sar_responder (NSTEP=8, RDY_LAT=3). Expected
// comparison results are pushed to a queue when a request is driven and
// popped when the responder raises ms_sar_rdy. Inputs change on the falling
// clk edge and outputs are sampled there as well.
module tb_sar_responder;

    localparam int NSTEP   = 8;
    localparam int RDY_LAT = 3;

    logic             clk;
    logic             rst;
    logic [NSTEP-1:0] vin_code;
    logic             ms_sar_sample;
    logic             ms_sar_clock;
    logic [NSTEP-1:0] ms_sar_sw;
    logic [NSTEP-1:0] ms_sar_swb;
    logic             ms_sar_dh;
    logic             ms_sar_dl;
    logic             ms_sar_rdy;
    logic [NSTEP-1:0] held_code;
    logic             prot_err;

    int checks = 0;
    int errors = 0;

    logic [1:0] expQ[$];

    sar_responder #(
        .NSTEP  (NSTEP),
        .RDY_LAT(RDY_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .vin_code     (vin_code),
        .ms_sar_sample(ms_sar_sample),
        .ms_sar_clock (ms_sar_clock),
        .ms_sar_sw    (ms_sar_sw),
        .ms_sar_swb   (ms_sar_swb),
        .ms_sar_dh    (ms_sar_dh),
        .ms_sar_dl    (ms_sar_dl),
        .ms_sar_rdy   (ms_sar_rdy),
        .held_code    (held_code),
        .prot_err     (prot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for rdy to reach a level; ok reports whether it did.
    task automatic waitRdy(input logic level, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (ms_sar_rdy === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic applyReset();
        rst           = 1'b1;
        vin_code      = '0;
        ms_sar_sample = 1'b0;
        ms_sar_clock  = 1'b0;
        ms_sar_sw     = '0;
        ms_sar_swb    = '1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    // Track v for a few cycles, then drop sample and settle in HOLD.
    task automatic setupHold(input logic [NSTEP-1:0] v);
        vin_code      = v;
        ms_sar_sample = 1'b1;
        tick(3);
        ms_sar_sample = 1'b0;
        tick(2);
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        vin_code      = 8'hAB;
        ms_sar_sample = 1'b1;
        ms_sar_clock  = 1'b0;
        ms_sar_sw     = '0;
        ms_sar_swb    = '1;
        tick(3);
        checks++;
        if ({ms_sar_dh, ms_sar_dl, ms_sar_rdy, prot_err} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags dh/dl/rdy/err=%b required 0000",
                     {ms_sar_dh, ms_sar_dl, ms_sar_rdy, prot_err});
        end
        checks++;
        if (held_code !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_held held_code=%02h required 00", held_code);
        end
        ms_sar_sample = 1'b0;
        rst = 1'b0;
        tick(2);
        checks++;
        if (held_code !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_release_held held_code=%02h required 00", held_code);
        end
    endtask

    // Runs an MSB-first binary search against a held vin and checks every step.
    task automatic test_conversion(input logic [NSTEP-1:0] vin);
        logic [NSTEP-1:0] code;
        logic [NSTEP-1:0] trial;
        logic [1:0]       exp;
        bit               ok;
        setupHold(vin);
        code = '0;
        for (int i = NSTEP - 1; i >= 0; i--) begin
            trial = code | (8'h01 << i);
            expQ.push_back({vin > trial, vin < trial});
            ms_sar_sw    = trial;
            ms_sar_swb   = ~trial;
            ms_sar_clock = 1'b1;
            waitRdy(1'b1, 20, ok);
            exp = expQ.pop_front();
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL conv_rdy_rise trial=%02h rdy=%b required 1", trial, ms_sar_rdy);
            end
            checks++;
            if ({ms_sar_dh, ms_sar_dl} !== exp) begin
                errors++;
                $display("[TB] FAIL conv_result trial=%02h dh,dl=%b required %b",
                         trial, {ms_sar_dh, ms_sar_dl}, exp);
            end
            if (vin >= trial) code = trial;
            ms_sar_clock = 1'b0;
            waitRdy(1'b0, 20, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL conv_rdy_fall trial=%02h rdy=%b required 0", trial, ms_sar_rdy);
            end
        end
        checks++;
        if (held_code !== vin) begin
            errors++;
            $display("[TB] FAIL conv_held held_code=%02h required %02h", held_code, vin);
        end
        checks++;
        if (prot_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL conv_prot_err prot_err=%b required 0", prot_err);
        end
    endtask

    task automatic test_full_conversion();
        applyReset();
        test_conversion(8'hA5);
    endtask

    task automatic test_latency();
        logic [1:0] exp;
        applyReset();
        setupHold(8'h40);
        ms_sar_sw  = 8'h20;
        ms_sar_swb = ~8'h20;
        expQ.push_back(2'b10);
        ms_sar_clock = 1'b1;
        // The next posedge samples the rise (edge k); rdy is due at k+3.
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checks++;
            if (ms_sar_rdy !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL latency_rise edge k+%0d rdy=%b required %b",
                         i, ms_sar_rdy, (i == 3));
            end
        end
        exp = expQ.pop_front();
        checks++;
        if ({ms_sar_dh, ms_sar_dl} !== exp) begin
            errors++;
            $display("[TB] FAIL latency_result dh,dl=%b required %b", {ms_sar_dh, ms_sar_dl}, exp);
        end
        tick(3);
        ms_sar_clock = 1'b0;
        tick(1);
        checks++;
        if (ms_sar_rdy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL latency_fall_m rdy=%b required 1", ms_sar_rdy);
        end
        tick(1);
        checks++;
        if (ms_sar_rdy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL latency_fall_m1 rdy=%b required 0", ms_sar_rdy);
        end
    endtask

    task automatic test_hold_integrity();
        bit ok;
        applyReset();
        ms_sar_sample = 1'b1;
        vin_code      = 8'h11;
        tick(2);
        vin_code = 8'h3C;
        tick(1);
        checks++;
        if (held_code !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL track_follow held_code=%02h required 3c", held_code);
        end
        ms_sar_sample = 1'b0;
        tick(1);
        vin_code = 8'hFF;
        tick(3);
        checks++;
        if (held_code !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL hold_keep held_code=%02h required 3c", held_code);
        end
        ms_sar_sw    = 8'h3C;
        ms_sar_swb   = ~8'h3C;
        expQ.push_back(2'b00);
        ms_sar_clock = 1'b1;
        waitRdy(1'b1, 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL hold_rdy rdy=%b required 1", ms_sar_rdy);
        end
        checks++;
        if ({ms_sar_dh, ms_sar_dl} !== expQ.pop_front()) begin
            errors++;
            $display("[TB] FAIL hold_equal dh,dl=%b required 00", {ms_sar_dh, ms_sar_dl});
        end
        ms_sar_clock = 1'b0;
        tick(3);
    endtask

    task automatic test_prot_swb();
        applyReset();
        setupHold(8'h90);
        checks++;
        if (prot_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL swb_pre prot_err=%b required 0", prot_err);
        end
        ms_sar_sw    = 8'h80;
        ms_sar_swb   = 8'h00;
        ms_sar_clock = 1'b1;
        tick(2);
        checks++;
        if (prot_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL swb_set prot_err=%b required 1", prot_err);
        end
        ms_sar_clock = 1'b0;
        tick(100);
        checks++;
        if (prot_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL swb_sticky prot_err=%b required 1", prot_err);
        end
    endtask

    task automatic test_prot_track();
        int rdySeen;
        applyReset();
        vin_code      = 8'h55;
        ms_sar_sample = 1'b1;
        ms_sar_sw     = 8'h10;
        ms_sar_swb    = ~8'h10;
        tick(2);
        ms_sar_clock = 1'b1;
        rdySeen = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (ms_sar_rdy === 1'b1) rdySeen++;
        end
        checks++;
        if (prot_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL track_req_err prot_err=%b required 1", prot_err);
        end
        checks++;
        if (rdySeen !== 0) begin
            errors++;
            $display("[TB] FAIL track_req_rdy rdy high cycles=%0d required 0", rdySeen);
        end
        ms_sar_clock  = 1'b0;
        ms_sar_sample = 1'b0;
        tick(2);
    endtask

    task automatic test_abort_sample();
        int rdySeen;
        applyReset();
        setupHold(8'h77);
        ms_sar_sw    = 8'h10;
        ms_sar_swb   = ~8'h10;
        ms_sar_clock = 1'b1;
        tick(1);
        ms_sar_sample = 1'b1;
        rdySeen = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (ms_sar_rdy === 1'b1) rdySeen++;
        end
        checks++;
        if (rdySeen !== 0 || {ms_sar_dh, ms_sar_dl} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL abort_sample rdy high cycles=%0d dh,dl=%b required 0 and 00",
                     rdySeen, {ms_sar_dh, ms_sar_dl});
        end
        vin_code = 8'h12;
        tick(2);
        checks++;
        if (held_code !== 8'h12) begin
            errors++;
            $display("[TB] FAIL abort_sample_track held_code=%02h required 12", held_code);
        end
        ms_sar_sample = 1'b0;
        ms_sar_clock  = 1'b0;
        tick(2);
    endtask

    task automatic test_abort_fall();
        int rdySeen;
        applyReset();
        setupHold(8'h77);
        ms_sar_sw    = 8'h10;
        ms_sar_swb   = ~8'h10;
        ms_sar_clock = 1'b1;
        tick(1);
        ms_sar_clock = 1'b0;
        rdySeen = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (ms_sar_rdy === 1'b1) rdySeen++;
        end
        checks++;
        if (rdySeen !== 0 || {ms_sar_dh, ms_sar_dl} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL abort_fall rdy high cycles=%0d dh,dl=%b required 0 and 00",
                     rdySeen, {ms_sar_dh, ms_sar_dl});
        end
    endtask

    task automatic test_reset_mid_conv();
        applyReset();
        setupHold(8'h33);
        // Bad complement sets prot_err so the reset has something to clear.
        ms_sar_sw    = 8'h20;
        ms_sar_swb   = 8'h00;
        ms_sar_clock = 1'b1;
        tick(2);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({ms_sar_dh, ms_sar_dl, ms_sar_rdy, prot_err} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midreset_flags dh/dl/rdy/err=%b required 0000",
                     {ms_sar_dh, ms_sar_dl, ms_sar_rdy, prot_err});
        end
        checks++;
        if (held_code !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midreset_held held_code=%02h required 00", held_code);
        end
        ms_sar_clock = 1'b0;
        ms_sar_swb   = ~8'h20;
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        test_conversion(8'h5A);
    endtask

    initial begin
        test_reset();
        test_full_conversion();
        test_latency();
        test_hold_integrity();
        test_prot_swb();
        test_prot_track();
        test_abort_sample();
        test_abort_fall();
        test_reset_mid_conv();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
